// File: rtl/ram_arbiter_if.sv
// Bus bundle between the system RAM arbiter and its three neighbours:
// the CPU memory port, the secondary requester and the RAM macro.
//
// Handshake semantics: the CPU side has no handshake; its strobes are
// qualified by clk_en and always win the RAM port. The secondary side is a
// level request: sec_req (with sec_we/sec_addr/sec_wdata stable) is held
// until a one-cycle sec_ack pulse, which marks completion; read data is
// valid on sec_rdata in the ack cycle and held afterwards. sec_req is
// ignored in the ack cycle itself.
interface ram_arbiter_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 4
);
  // CPU port
  logic                  clk_en;
  logic                  cpu_write_en;
  logic                  cpu_read_en;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_write_data;
  logic [DATA_WIDTH-1:0] cpu_read_data;
  // Secondary port
  logic                  sec_req;
  logic                  sec_we;
  logic [ADDR_WIDTH-1:0] sec_addr;
  logic [DATA_WIDTH-1:0] sec_wdata;
  logic                  sec_ack;
  logic [DATA_WIDTH-1:0] sec_rdata;
  logic                  sec_starved;
  // RAM macro port
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Environment side: CPU, secondary requester and the RAM macro.
  modport master (
    output clk_en, cpu_write_en, cpu_read_en, cpu_addr, cpu_write_data,
    input  cpu_read_data,
    output sec_req, sec_we, sec_addr, sec_wdata,
    input  sec_ack, sec_rdata, sec_starved,
    input  ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );

  // Arbiter side.
  modport slave (
    input  clk_en, cpu_write_en, cpu_read_en, cpu_addr, cpu_write_data,
    output cpu_read_data,
    input  sec_req, sec_we, sec_addr, sec_wdata,
    output sec_ack, sec_rdata, sec_starved,
    output ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port arbiter for the single-port synchronous system RAM.
// The CPU owns the RAM on its clk_en cycles; the secondary requester is
// granted in the clk_en=0 gaps. Read data is steered back by a one-cycle
// ownership tag that follows the RAM's read latency, so a CPU read issued
// right after a secondary read cannot be confused with it.
module ram_arbiter #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 4,
  parameter int STARVE_LIMIT = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  ram_arbiter_if.slave bus,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUED = 2'd1,
    ST_ACK    = 2'd2
  } state_t;

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_LIMIT);

  state_t                state_q, state_d;

  logic                  cpu_cycle;
  logic                  sec_grant;
  logic                  cpu_rd_issue;
  logic                  sec_rd_issue;

  logic                  ram_we_c;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;

  logic                  tag_valid_q, tag_valid_d;
  logic                  tag_sec_q, tag_sec_d;

  logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_WIDTH-1:0] sec_rdata_q, sec_rdata_d;

  logic                  sec_ack_q, sec_ack_d;
  logic [7:0]            starve_cnt_q, starve_cnt_d;
  logic                  sec_starved_q, sec_starved_d;

  // Ownership decision for this cycle; nothing is granted while in reset.
  always_comb begin
    cpu_cycle    = reset_n && bus.clk_en && (bus.cpu_write_en || bus.cpu_read_en);
    sec_grant    = reset_n && !bus.clk_en && (state_q == ST_IDLE) && bus.sec_req;
    // A CPU write beats a simultaneous CPU read, so a read issues only alone.
    cpu_rd_issue = cpu_cycle && !bus.cpu_write_en;
    sec_rd_issue = sec_grant && !bus.sec_we;
  end

  // RAM drive: owner's signals pass straight through; address/data hold when idle.
  always_comb begin
    ram_we_c    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if (cpu_cycle) begin
      ram_we_c    = bus.cpu_write_en;
      ram_addr_d  = bus.cpu_addr;
      ram_wdata_d = bus.cpu_write_data;
    end else if (sec_grant) begin
      ram_we_c    = bus.sec_we;
      ram_addr_d  = bus.sec_addr;
      ram_wdata_d = bus.sec_wdata;
    end
  end

  // Read-return steering: data lands only where the tag from last cycle says.
  always_comb begin
    tag_valid_d = cpu_rd_issue || sec_rd_issue;
    tag_sec_d   = sec_rd_issue;
    cpu_rdata_d = cpu_rdata_q;
    sec_rdata_d = sec_rdata_q;
    if (tag_valid_q && !tag_sec_q) begin
      cpu_rdata_d = bus.ram_rdata;
    end
    if (tag_valid_q && tag_sec_q) begin
      sec_rdata_d = bus.ram_rdata;
    end
  end

  // Secondary FSM next state: grant -> issued -> ack -> idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (sec_grant) state_d = ST_ISSUED;
      ST_ISSUED: state_d = ST_ACK;
      ST_ACK:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Secondary FSM outputs: registered ack pulse for the whole ACK state.
  always_comb begin
    sec_ack_d = (state_d == ST_ACK);
    dbg_state = state_q;
  end

  // Starvation counter: counts idle-FSM cycles the request is refused.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (sec_grant || !bus.sec_req) begin
      starve_cnt_d = 8'd0;
    end else if ((state_q == ST_IDLE) && (starve_cnt_q != 8'hFF)) begin
      starve_cnt_d = starve_cnt_q + 8'd1;
    end
    sec_starved_d = (starve_cnt_d >= STARVE_LIM);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and status registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      tag_valid_q   <= 1'b0;
      tag_sec_q     <= 1'b0;
      cpu_rdata_q   <= '0;
      sec_rdata_q   <= '0;
      sec_ack_q     <= 1'b0;
      starve_cnt_q  <= 8'd0;
      sec_starved_q <= 1'b0;
    end else begin
      ram_addr_q    <= ram_addr_d;
      ram_wdata_q   <= ram_wdata_d;
      tag_valid_q   <= tag_valid_d;
      tag_sec_q     <= tag_sec_d;
      cpu_rdata_q   <= cpu_rdata_d;
      sec_rdata_q   <= sec_rdata_d;
      sec_ack_q     <= sec_ack_d;
      starve_cnt_q  <= starve_cnt_d;
      sec_starved_q <= sec_starved_d;
    end
  end

  // Output wiring.
  always_comb begin
    bus.ram_we        = ram_we_c;
    bus.ram_addr      = ram_addr_d;
    bus.ram_wdata     = ram_wdata_d;
    bus.cpu_read_data = cpu_rdata_q;
    bus.sec_rdata     = sec_rdata_q;
    bus.sec_ack       = sec_ack_q;
    bus.sec_starved   = sec_starved_q;
  end

endmodule
